pwm_capture: RTL and testbench

//  Measures an external PWM waveform: high time and period, in clk cycles, per rising-edge-to-rising-edge cycle.
//  It is the receive-side counterpart of the PWM generator and a memory-mapped peripheral on the same CPU bus.

---
 rtl/pwm_capture_pkg.sv | 25 ++
 rtl/pwm_capture_sync_edge.sv | 29 ++
 rtl/pwm_capture.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and register map for the PWM capture peripheral.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } state_t;

  // Register index taken from address_in[3:2]
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegHigh   = 2'd1;
  localparam logic [1:0] RegPeriod = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlClearBit  = 1;

  localparam int unsigned StatusValidBit    = 0;
  localparam int unsigned StatusTimeoutBit  = 1;
  localparam int unsigned StatusOverflowBit = 2;
  localparam int unsigned StatusLevelBit    = 3;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_q1, sync_q2, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign level = sync_q2;
  assign rise  = sync_q2 & ~prev_q;
  assign fall  = ~sync_q2 & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture peripheral: measures high time and rising-to-rising period in clk cycles,
// latches them as an atomic pair and reports static inputs through a timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  monitor,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimeoutW-1:0]  TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimeoutW-1:0]  TimeoutOne  = TimeoutW'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax      = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  enable_q, enable_d;
  logic [CNT_WIDTH-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0]  per_cnt_q, per_cnt_d;
  logic [TimeoutW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_WIDTH-1:0]  high_lat_q, high_lat_d;
  logic [CNT_WIDTH-1:0]  period_lat_q, period_lat_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;
  logic                  overflow_q, overflow_d;

  logic                  level, rise, fall;
  logic [1:0]            reg_idx;
  logic                  ctrl_wr, ctrl_clear;
  logic                  hi_sat, per_sat;
  logic [CNT_WIDTH-1:0]  hi_inc, per_inc;
  logic                  timeout_hit;
  logic [3:0]            status;
  logic                  unused_bus_bits;

  sync_edge u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (pwm_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  assign reg_idx    = address_in[3:2];
  assign ctrl_wr    = sel_in && write_mask_in[0] && (reg_idx == RegCtrl);
  assign ctrl_clear = ctrl_wr && write_value_in[CtrlClearBit];

  assign unused_bus_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                             write_value_in[31:2]};

  assign hi_sat  = (hi_cnt_q == CntMax);
  assign per_sat = (per_cnt_q == CntMax);
  assign hi_inc  = hi_sat ? hi_cnt_q : hi_cnt_q + CntOne;
  assign per_inc = per_sat ? per_cnt_q : per_cnt_q + CntOne;

  // An edge in the same cycle always wins over the timeout.
  assign timeout_hit = (state_q != StIdle) && !rise && !fall && (idle_cnt_q == TimeoutLast);

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    hi_cnt_d     = hi_cnt_q;
    per_cnt_d    = per_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    high_lat_d   = high_lat_q;
    period_lat_d = period_lat_q;
    valid_d      = valid_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;

    if (ctrl_wr) begin
      enable_d = write_value_in[CtrlEnableBit];
    end

    if (ctrl_clear) begin
      // Clear overrides any latch or timeout happening in the same cycle.
      valid_d      = 1'b0;
      timeout_d    = 1'b0;
      overflow_d   = 1'b0;
      high_lat_d   = '0;
      period_lat_d = '0;
      hi_cnt_d     = '0;
      per_cnt_d    = '0;
      idle_cnt_d   = '0;
      state_d      = enable_d ? StArm : StIdle;
    end else if (!enable_d) begin
      state_d    = StIdle;
      hi_cnt_d   = '0;
      per_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = (rise || fall) ? '0 : idle_cnt_q + TimeoutOne;
      unique case (state_q)
        StIdle: begin
          state_d    = StArm;
          hi_cnt_d   = '0;
          per_cnt_d  = '0;
          idle_cnt_d = '0;
        end
        StArm: begin
          if (rise) begin
            state_d   = StHigh;
            hi_cnt_d  = CntOne;
            per_cnt_d = CntOne;
          end
        end
        StHigh: begin
          if (fall) begin
            state_d   = StLow;
            per_cnt_d = per_inc;
            if (per_sat) overflow_d = 1'b1;
          end else begin
            hi_cnt_d  = hi_inc;
            per_cnt_d = per_inc;
            if (hi_sat || per_sat) overflow_d = 1'b1;
          end
        end
        StLow: begin
          if (rise) begin
            high_lat_d   = hi_cnt_q;
            period_lat_d = per_cnt_q;
            valid_d      = 1'b1;
            hi_cnt_d     = CntOne;
            per_cnt_d    = CntOne;
            state_d      = StHigh;
          end else begin
            per_cnt_d = per_inc;
            if (per_sat) overflow_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (timeout_hit) begin
        timeout_d    = 1'b1;
        valid_d      = 1'b1;
        period_lat_d = '0;
        high_lat_d   = level ? CntMax : '0;
        hi_cnt_d     = '0;
        per_cnt_d    = '0;
        idle_cnt_d   = '0;
        state_d      = StArm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      enable_q     <= 1'b0;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      high_lat_q   <= '0;
      period_lat_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      high_lat_q   <= high_lat_d;
      period_lat_q <= period_lat_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    status                    = '0;
    status[StatusValidBit]    = valid_q;
    status[StatusTimeoutBit]  = timeout_q;
    status[StatusOverflowBit] = overflow_q;
    status[StatusLevelBit]    = level;
  end

  // Reads see registered latches only, so a read on a latch cycle returns the old pair.
  always_comb begin
    read_value_out = '0;
    if (sel_in && read_in) begin
      unique case (reg_idx)
        RegCtrl:   read_value_out = {31'b0, enable_q};
        RegHigh:   read_value_out = 32'(high_lat_q);
        RegPeriod: read_value_out = 32'(period_lat_q);
        RegStatus: read_value_out = {28'b0, status};
        default:   read_value_out = '0;
      endcase
    end
  end

  assign ready_out = sel_in;
  assign monitor   = high_lat_q[CNT_WIDTH-1 -: 8];

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 24-bit instance (a) and an 8-bit saturating instance (b).
module tb_pwm_capture;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] per;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pwm_a, pwm_b;
  logic [7:0]  monitor_a, monitor_b;
  logic [31:0] address;
  logic        sel_a, sel_b;
  logic        read_in;
  logic [31:0] read_value_a, read_value_b;
  logic [3:0]  write_mask;
  logic [31:0] write_value;
  logic        ready_a, ready_b;

  int          n_pass, n_fail, n_total;
  exp_t        sb[$];
  logic [31:0] prev_hi, prev_per;
  logic [31:0] v;

  pwm_capture #(.CNT_WIDTH(24), .TIMEOUT_CYCLES(1200)) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .pwm_in         (pwm_a),
    .monitor        (monitor_a),
    .address_in     (address),
    .sel_in         (sel_a),
    .read_in        (read_in),
    .read_value_out (read_value_a),
    .write_mask_in  (write_mask),
    .write_value_in (write_value),
    .ready_out      (ready_a)
  );

  pwm_capture #(.CNT_WIDTH(8), .TIMEOUT_CYCLES(400)) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .pwm_in         (pwm_b),
    .monitor        (monitor_b),
    .address_in     (address),
    .sel_in         (sel_b),
    .read_in        (read_in),
    .read_value_out (read_value_b),
    .write_mask_in  (write_mask),
    .write_value_in (write_value),
    .ready_out      (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    sel_a = 1'b0;
    sel_b = 1'b0;
    read_in = 1'b0;
    write_mask = 4'h0;
    write_value = 32'h0;
  endtask

  task automatic set_pwm(input int d, input logic lvl);
    if (d == 0) pwm_a = lvl;
    else pwm_b = lvl;
  endtask

  // Combinational read, sampled 1 time unit after the inputs settle (away from posedge).
  task automatic rd(input int d, input logic [1:0] r, output logic [31:0] val);
    address = {28'b0, r, 2'b00};
    write_mask = 4'h0;
    read_in = 1'b1;
    if (d == 0) sel_a = 1'b1;
    else sel_b = 1'b1;
    #1;
    val = (d == 0) ? read_value_a : read_value_b;
    chk("ready_when_selected", 32'((d == 0) ? ready_a : ready_b), 32'd1);
    sel_a = 1'b0;
    sel_b = 1'b0;
    read_in = 1'b0;
  endtask

  task automatic wr_ctrl(input int d, input logic [31:0] val);
    @(negedge clk);
    idle_bus();
    address = 32'h0;
    write_mask = 4'h1;
    write_value = val;
    if (d == 0) sel_a = 1'b1;
    else sel_b = 1'b1;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic hold(input int d, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_pwm(d, lvl);
    end
  endtask

  function automatic exp_t sat_exp(input int d, input int hi, input int per);
    int mx;
    exp_t e;
    mx = (d == 0) ? 32'h00FF_FFFF : 255;
    e.hi  = (hi > mx) ? mx : hi;
    e.per = (per > mx) ? mx : per;
    return e;
  endfunction

  // One PWM period starting with a rising edge. mode: 0 none, 1 check latched pair,
  // 2 expect no latch yet, 3 clear on the latch cycle then expect zeros.
  task automatic run_period(input int d, input int hi, input int per, input int mode,
                            input bit push);
    exp_t e;
    logic [31:0] h, p, s;
    e.hi = 32'h0;
    e.per = 32'h0;
    if (mode == 1 || mode == 3) begin
      chk("scoreboard_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
    end
    for (int c = 0; c < per; c++) begin
      @(negedge clk);
      idle_bus();
      set_pwm(d, c < hi);
      if (mode == 3 && c == 2) begin
        address = 32'h0;
        write_mask = 4'h1;
        write_value = 32'h3;
        if (d == 0) sel_a = 1'b1;
        else sel_b = 1'b1;
      end
      if (mode == 1 && c <= 8) begin
        rd(d, 2'd1, h);
        rd(d, 2'd2, p);
        chk("no_torn_pair", 32'(({h, p} == {prev_hi, prev_per}) || ({h, p} == {e.hi, e.per})),
            32'd1);
      end
      if (c == 6) begin
        if (mode == 1) begin
          rd(d, 2'd3, s);
          chk("high", h, e.hi);
          chk("period", p, e.per);
          chk("valid", s & 32'h1, 32'h1);
          prev_hi = e.hi;
          prev_per = e.per;
        end else if (mode == 2) begin
          rd(d, 2'd3, s);
          chk("no_latch_after_rearm", s & 32'h1, 32'h0);
        end else if (mode == 3) begin
          rd(d, 2'd1, h);
          rd(d, 2'd2, p);
          rd(d, 2'd3, s);
          chk("clear_high", h, 32'h0);
          chk("clear_period", p, 32'h0);
          chk("clear_flags", s & 32'h7, 32'h0);
          prev_hi = 32'h0;
          prev_per = 32'h0;
        end
      end
    end
    if (push) sb.push_back(sat_exp(d, hi, per));
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_total = 0;
    prev_hi = 32'h0;
    prev_per = 32'h0;
    reset = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    address = 32'h0;
    idle_bus();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    rd(0, 2'd0, v); chk("reset_ctrl", v, 32'h0);
    rd(0, 2'd1, v); chk("reset_high", v, 32'h0);
    rd(0, 2'd2, v); chk("reset_period", v, 32'h0);
    rd(0, 2'd3, v); chk("reset_status", v, 32'h0);
    read_in = 1'b1;
    address = 32'h4;
    #1;
    chk("unselected_read_zero", read_value_a, 32'h0);
    chk("ready_unselected", 32'(ready_a), 32'h0);
    read_in = 1'b0;

    // Saturation on the 8-bit instance, then clear and re-measure
    wr_ctrl(1, 32'h1);
    run_period(1, 100, 300, 0, 1'b1);
    run_period(1, 100, 300, 1, 1'b0);
    rd(1, 2'd3, v); chk("sat_status", v, 32'h5);
    chk("monitor_b", 32'(monitor_b), 32'h64);
    wr_ctrl(1, 32'h3);
    rd(1, 2'd3, v); chk("sat_clear_status", v, 32'h0);
    rd(1, 2'd1, v); chk("sat_clear_high", v, 32'h0);
    prev_hi = 32'h0;
    prev_per = 32'h0;
    run_period(1, 50, 200, 0, 1'b1);
    run_period(1, 50, 200, 1, 1'b0);
    rd(1, 2'd3, v); chk("after_clear_status", v, 32'h1);

    // 25% duty, then 75% duty mid-run
    prev_hi = 32'h0;
    prev_per = 32'h0;
    wr_ctrl(0, 32'h1);
    rd(0, 2'd0, v); chk("ctrl_enable", v, 32'h1);
    run_period(0, 256, 1024, 0, 1'b1);
    run_period(0, 256, 1024, 1, 1'b1);
    run_period(0, 256, 1024, 1, 1'b1);
    run_period(0, 768, 1024, 1, 1'b1);
    run_period(0, 768, 1024, 1, 1'b0);

    // Static input: held high, then held low, then resume
    hold(0, 1'b1, 1300);
    rd(0, 2'd1, v); chk("timeout_high_level", v, 32'h00FF_FFFF);
    rd(0, 2'd2, v); chk("timeout_period", v, 32'h0);
    rd(0, 2'd3, v); chk("timeout_status_hi", v, 32'hB);
    chk("monitor_a_ff", 32'(monitor_a), 32'hFF);
    hold(0, 1'b0, 1300);
    rd(0, 2'd1, v); chk("timeout_low_level", v, 32'h0);
    rd(0, 2'd3, v); chk("timeout_status_lo", v, 32'h3);
    prev_hi = 32'h0;
    prev_per = 32'h0;
    run_period(0, 256, 1024, 0, 1'b1);
    run_period(0, 256, 1024, 1, 1'b0);
    rd(0, 2'd3, v); chk("timeout_sticky", v & 32'h2, 32'h2);
    wr_ctrl(0, 32'h3);
    rd(0, 2'd3, v); chk("clear_status", v, 32'h0);
    rd(0, 2'd1, v); chk("clear_high_a", v, 32'h0);
    rd(0, 2'd2, v); chk("clear_period_a", v, 32'h0);
    prev_hi = 32'h0;
    prev_per = 32'h0;

    // Disable mid-HIGH and re-enable: no latch until a full new cycle
    hold(0, 1'b1, 20);
    wr_ctrl(0, 32'h0);
    wr_ctrl(0, 32'h1);
    rd(0, 2'd0, v); chk("reenable_ctrl", v, 32'h1);
    hold(0, 1'b1, 30);
    hold(0, 1'b0, 400);
    rd(0, 2'd3, v); chk("reenable_no_valid", v, 32'h0);
    run_period(0, 300, 900, 2, 1'b1);
    run_period(0, 300, 900, 1, 1'b1);

    // Clear on the exact latch cycle, then re-arm and measure
    run_period(0, 300, 900, 3, 1'b0);
    run_period(0, 300, 900, 0, 1'b1);
    run_period(0, 300, 900, 1, 1'b0);

    // Reset mid-LOW
    hold(0, 1'b1, 100);
    hold(0, 1'b0, 50);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(0, 2'd0, v); chk("midreset_ctrl", v, 32'h0);
    rd(0, 2'd1, v); chk("midreset_high", v, 32'h0);
    rd(0, 2'd2, v); chk("midreset_period", v, 32'h0);
    rd(0, 2'd3, v); chk("midreset_status", v, 32'h0);
    chk("midreset_monitor", 32'(monitor_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
